// File: rtl/contador_if.sv
// contador_if: control, data and status signals of the universal counter
interface contador_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic [2:0]       mode;
  logic [WIDTH-1:0] load_val;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic             tc;
  logic             zero;
  modport master (output enable, mode, load_val, serial_in, input q, serial_out, tc, zero);
  modport slave  (input enable, mode, load_val, serial_in, output q, serial_out, tc, zero);
endinterface

// File: rtl/contador_universal.sv
// contador_universal: up/down modulo counter fused with a shift/rotate register and saturating parallel load
module contador_universal #(
  parameter int          WIDTH     = 4,
  parameter int unsigned MAX_COUNT = (2**WIDTH)-1,
  parameter int unsigned RESET_VAL = 0
) (
  input logic       clk,
  input logic       reset,
  contador_if.slave bus
);
  localparam logic [WIDTH-1:0] MAXV = MAX_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RSTV = RESET_VAL[WIDTH-1:0];
  if (WIDTH < 2 || 64'(MAX_COUNT) >= (64'd1 << WIDTH) || RESET_VAL > MAX_COUNT) begin : g_bad_params
    $error("contador_universal: illegal WIDTH/MAX_COUNT/RESET_VAL combination");
  end
  logic [WIDTH-1:0] q, q_n;
  logic             so, so_n, tc, tc_n;
  always_comb begin
    q_n  = q;
    so_n = so;
    tc_n = 1'b0;
    if (bus.enable)
      case (bus.mode)
        3'b001: begin
          q_n  = (q >= MAXV) ? '0 : q + 1'b1;
          tc_n = q >= MAXV;
        end
        3'b010: begin
          q_n  = (q == '0 || q > MAXV) ? MAXV : q - 1'b1;
          tc_n = q == '0;
        end
        3'b011: begin
          q_n  = {q[WIDTH-2:0], bus.serial_in};
          so_n = q[WIDTH-1];
        end
        3'b100: begin
          q_n  = {bus.serial_in, q[WIDTH-1:1]};
          so_n = q[0];
        end
        3'b101: begin
          q_n  = {q[WIDTH-2:0], q[WIDTH-1]};
          so_n = q[WIDTH-1];
        end
        3'b110: begin
          q_n  = {q[0], q[WIDTH-1:1]};
          so_n = q[0];
        end
        3'b111: q_n = (bus.load_val > MAXV) ? MAXV : bus.load_val;
        default: ;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q  <= RSTV;
      so <= 1'b0;
      tc <= 1'b0;
    end else begin
      q  <= q_n;
      so <= so_n;
      tc <= tc_n;
    end
  assign bus.q          = q;
  assign bus.serial_out = so;
  assign bus.tc         = tc;
  assign bus.zero       = q == '0;
endmodule

// File: tb/tb_contador_universal.sv
// tb_contador_universal: directed checks of a MAX_COUNT=9 and a MAX_COUNT=15 build
module tb_contador_universal;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  contador_if #(.WIDTH(4)) b9 ();
  contador_if #(.WIDTH(4)) b15 ();
  contador_universal #(.WIDTH(4), .MAX_COUNT(9), .RESET_VAL(0)) dut9 (.clk(clk), .reset(reset), .bus(b9));
  contador_universal #(.WIDTH(4), .MAX_COUNT(15), .RESET_VAL(0)) dut15 (.clk(clk), .reset(reset), .bus(b15));
  task automatic drive(input logic en, input logic [2:0] m, input logic [3:0] lv, input logic si);
    b9.enable = en;  b9.mode = m;  b9.load_val = lv;  b9.serial_in = si;
    b15.enable = en; b15.mode = m; b15.load_val = lv; b15.serial_in = si;
  endtask
  task automatic step(input logic en, input logic [2:0] m, input logic [3:0] lv, input logic si);
    drive(en, m, lv, si);
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    drive(1'b0, 3'b000, 4'd0, 1'b0);
    #1 reset = 1'b0;
    step(1'b1, 3'b111, 4'd8, 1'b0);
    step(1'b1, 3'b011, 4'd0, 1'b0);
    step(1'b1, 3'b111, 4'd5, 1'b0);
    checks++;
    if ({b9.q, b9.serial_out} !== {4'd5, 1'b1}) begin
      failures++; $display("FAIL pre_reset q/so got=%0d/%0b exp=5/1", b9.q, b9.serial_out);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({b9.q, b9.tc, b9.serial_out, b9.zero} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL async_reset q/tc/so/zero got=%0d/%0b/%0b/%0b exp=0/0/0/1", b9.q, b9.tc, b9.serial_out, b9.zero);
    end
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b001, 4'd0, 1'b0);
      checks++;
      if ({b9.q, b9.tc} !== {4'd0, 1'b0}) begin
        failures++; $display("FAIL enable_low[%0d] q/tc got=%0d/%0b exp=0/0", i, b9.q, b9.tc);
      end
    end
  endtask
  task automatic test_count_up;
    logic [3:0] e;
    for (int i = 0; i < 12; i++) begin
      e = 4'((i + 1) % 10);
      step(1'b1, 3'b001, 4'd0, 1'b0);
      checks++;
      if ({b9.q, b9.tc, b9.zero} !== {e, e == 4'd0, e == 4'd0}) begin
        failures++; $display("FAIL count_up[%0d] q/tc/zero got=%0d/%0b/%0b exp=%0d/%0b/%0b", i, b9.q, b9.tc, b9.zero, e, e == 4'd0, e == 4'd0);
      end
    end
  endtask
  task automatic test_count_down;
    logic [3:0] exp_q [3] = '{4'd0, 4'd9, 4'd8};
    logic       exp_tc [3] = '{1'b0, 1'b1, 1'b0};
    step(1'b1, 3'b111, 4'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b010, 4'd0, 1'b0);
      checks++;
      if ({b9.q, b9.tc} !== {exp_q[i], exp_tc[i]}) begin
        failures++; $display("FAIL count_down[%0d] q/tc got=%0d/%0b exp=%0d/%0b", i, b9.q, b9.tc, exp_q[i], exp_tc[i]);
      end
    end
    step(1'b1, 3'b111, 4'd15, 1'b0);
    checks++;
    if ({b9.q, b9.tc} !== {4'd9, 1'b0}) begin
      failures++; $display("FAIL load_saturate q/tc got=%0d/%0b exp=9/0", b9.q, b9.tc);
    end
  endtask
  task automatic test_shift_rotate;
    logic [2:0] m  [6] = '{3'b111, 3'b011, 3'b110, 3'b100, 3'b101, 3'b000};
    logic       si [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] eq [6] = '{4'b1011, 4'b0110, 4'b0011, 4'b1001, 4'b0011, 4'b0011};
    logic       es [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, m[i], 4'b1011, si[i]);
      checks++;
      if ({b15.q, b15.serial_out, b15.tc} !== {eq[i], es[i], 1'b0}) begin
        failures++; $display("FAIL shift_rotate[%0d] q/so/tc got=%b/%b/%b exp=%b/%b/0", i, b15.q, b15.serial_out, b15.tc, eq[i], es[i]);
      end
    end
  endtask
  task automatic test_wrap15;
    step(1'b1, 3'b111, 4'd14, 1'b0);
    step(1'b1, 3'b001, 4'd0, 1'b0);
    checks++;
    if ({b15.q, b15.tc} !== {4'd15, 1'b0}) begin
      failures++; $display("FAIL wrap15_pre q/tc got=%0d/%0b exp=15/0", b15.q, b15.tc);
    end
    step(1'b1, 3'b001, 4'd0, 1'b0);
    checks++;
    if ({b15.q, b15.tc} !== {4'd0, 1'b1}) begin
      failures++; $display("FAIL wrap15 q/tc got=%0d/%0b exp=0/1", b15.q, b15.tc);
    end
  endtask
  task automatic test_above_max;
    step(1'b1, 3'b111, 4'd8, 1'b0);
    step(1'b1, 3'b011, 4'd0, 1'b0);
    checks++;
    if ({b9.q, b9.serial_out} !== {4'd0, 1'b1}) begin
      failures++; $display("FAIL shl_msb_drop q/so got=%0d/%0b exp=0/1", b9.q, b9.serial_out);
    end
    step(1'b1, 3'b111, 4'd5, 1'b0);
    step(1'b1, 3'b011, 4'd0, 1'b0);
    checks++;
    if (b9.q !== 4'd10) begin
      failures++; $display("FAIL shl_above_max q got=%0d exp=10", b9.q);
    end
    step(1'b1, 3'b001, 4'd0, 1'b0);
    checks++;
    if ({b9.q, b9.tc, b9.serial_out} !== {4'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL up_from_above q/tc/so got=%0d/%0b/%0b exp=0/1/0", b9.q, b9.tc, b9.serial_out);
    end
    step(1'b1, 3'b111, 4'd5, 1'b0);
    step(1'b1, 3'b011, 4'd0, 1'b0);
    step(1'b1, 3'b010, 4'd0, 1'b0);
    checks++;
    if ({b9.q, b9.tc} !== {4'd9, 1'b0}) begin
      failures++; $display("FAIL down_from_above q/tc got=%0d/%0b exp=9/0", b9.q, b9.tc);
    end
  endtask
  task automatic test_enable_toggle;
    logic [3:0] eq [6] = '{4'd8, 4'd8, 4'd9, 4'd9, 4'd0, 4'd0};
    logic       et [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    step(1'b1, 3'b111, 4'd7, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(i % 2 == 0, 3'b001, 4'd0, 1'b0);
      checks++;
      if ({b9.q, b9.tc} !== {eq[i], et[i]}) begin
        failures++; $display("FAIL enable_toggle[%0d] q/tc got=%0d/%0b exp=%0d/%0b", i, b9.q, b9.tc, eq[i], et[i]);
      end
    end
    step(1'b1, 3'b001, 4'd0, 1'b0);
    step(1'b1, 3'b001, 4'd0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({b9.q, b9.tc} !== {4'd0, 1'b0}) begin
      failures++; $display("FAIL mid_count_reset q/tc got=%0d/%0b exp=0/0", b9.q, b9.tc);
    end
    @(negedge clk) reset = 1'b0;
  endtask
  initial begin
    test_reset;
    test_count_up;
    test_count_down;
    test_shift_rotate;
    test_wrap15;
    test_above_max;
    test_enable_toggle;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
